// File: rtl/id_exe_stage_reg.sv
`default_nettype none

`ifndef FUNC_SIZE
`define FUNC_SIZE 4
`endif
`ifndef MAX_LENGTH
`define MAX_LENGTH 32
`endif
`ifndef NOP_EXECUTE
`define NOP_EXECUTE 4'd0
`endif
`ifndef ADD_EXECUTE
`define ADD_EXECUTE 4'd1
`endif
`ifndef SUB_EXECUTE
`define SUB_EXECUTE 4'd2
`endif

// ============================================================================
//  Module      : id_exe_stage_reg
//  Description : Decode-to-execute pipeline register with a valid/ready
//                handshake and a one-entry skid buffer. A flush squashes
//                every held instruction into a NOP bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_exe_stage_reg #(
    parameter int FUNC_W = `FUNC_SIZE,
    parameter int DATA_W = `MAX_LENGTH,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FUNC_W-1:0] in_cmd,
    input  logic [DATA_W-1:0] in_val1,
    input  logic [DATA_W-1:0] in_val2,
    input  logic [REG_W-1:0]  in_dest,
    input  logic              in_wb_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FUNC_W-1:0] EXE_CMD,
    output logic [DATA_W-1:0] valuein1,
    output logic [DATA_W-1:0] valuein2,
    output logic [REG_W-1:0]  out_dest,
    output logic              out_wb_en
);

    // One instruction packed as {cmd, val1, val2, dest, wb_en}
    localparam int ENT_W = FUNC_W + 2 * DATA_W + REG_W + 1;

    localparam logic [FUNC_W-1:0] C_NOP_CMD = FUNC_W'(`NOP_EXECUTE);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   main_q, main_d;
    logic [ENT_W-1:0]   skid_q, skid_d;

    logic [ENT_W-1:0]   w_in_entry;
    logic               w_in_xfer;
    logic               w_out_xfer;

    logic [FUNC_W-1:0]  w_main_cmd;
    logic [DATA_W-1:0]  w_main_val1;
    logic [DATA_W-1:0]  w_main_val2;
    logic [REG_W-1:0]   w_main_dest;
    logic               w_main_wb;

    assign w_in_entry = {in_cmd, in_val1, in_val2, in_dest, in_wb_en};
    assign {w_main_cmd, w_main_val1, w_main_val2, w_main_dest, w_main_wb} = main_q;

    // Ready depends only on held state (and reset), never on out_ready, so
    // the handshake path from execute back to decode stays registered.
    assign in_ready   = rst & (state_q != ST_FULL);
    assign out_valid  = (state_q != ST_EMPTY);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // Idle cycles present a NOP with write-back disabled; operands keep
    // their last value so the ALU inputs do not toggle needlessly.
    assign EXE_CMD   = out_valid ? w_main_cmd : C_NOP_CMD;
    assign valuein1  = w_main_val1;
    assign valuein2  = w_main_val2;
    assign out_dest  = w_main_dest;
    assign out_wb_en = out_valid & w_main_wb;

    // Next-state and storage update; flush overrides every transfer
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        main_d  = w_in_entry;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_xfer && w_out_xfer) begin
                        main_d = w_in_entry;
                    end else if (w_out_xfer) begin
                        state_d = ST_EMPTY;
                    end else if (w_in_xfer) begin
                        skid_d  = w_in_entry;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and storage registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            main_q  <= {C_NOP_CMD, {(ENT_W - FUNC_W){1'b0}}};
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_exe_stage_reg.sv
`default_nettype none

`ifndef FUNC_SIZE
`define FUNC_SIZE 4
`endif
`ifndef MAX_LENGTH
`define MAX_LENGTH 32
`endif
`ifndef NOP_EXECUTE
`define NOP_EXECUTE 4'd0
`endif
`ifndef ADD_EXECUTE
`define ADD_EXECUTE 4'd1
`endif
`ifndef SUB_EXECUTE
`define SUB_EXECUTE 4'd2
`endif

// ============================================================================
//  Module      : tb_id_exe_stage_reg
//  Description : Directed and randomized self-checking bench for
//                id_exe_stage_reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_exe_stage_reg;

    localparam int FUNC_W = `FUNC_SIZE;
    localparam int DATA_W = `MAX_LENGTH;
    localparam int REG_W  = 5;
    localparam int WORD_W = FUNC_W + 2 * DATA_W + REG_W + 1;

    localparam logic [FUNC_W-1:0] C_NOP = FUNC_W'(`NOP_EXECUTE);
    localparam logic [FUNC_W-1:0] C_ADD = FUNC_W'(`ADD_EXECUTE);
    localparam logic [FUNC_W-1:0] C_SUB = FUNC_W'(`SUB_EXECUTE);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [FUNC_W-1:0] in_cmd;
    logic [DATA_W-1:0] in_val1;
    logic [DATA_W-1:0] in_val2;
    logic [REG_W-1:0]  in_dest;
    logic              in_wb_en;
    logic              out_valid;
    logic              out_ready;
    logic [FUNC_W-1:0] EXE_CMD;
    logic [DATA_W-1:0] valuein1;
    logic [DATA_W-1:0] valuein2;
    logic [REG_W-1:0]  out_dest;
    logic              out_wb_en;

    int n_checks = 0;
    int n_errors = 0;

    id_exe_stage_reg #(
        .FUNC_W (FUNC_W),
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cmd    (in_cmd),
        .in_val1   (in_val1),
        .in_val2   (in_val2),
        .in_dest   (in_dest),
        .in_wb_en  (in_wb_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .EXE_CMD   (EXE_CMD),
        .valuein1  (valuein1),
        .valuein2  (valuein2),
        .out_dest  (out_dest),
        .out_wb_en (out_wb_en)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [FUNC_W-1:0] c, input logic [DATA_W-1:0] v1,
                        input logic [DATA_W-1:0] v2, input logic [REG_W-1:0] d,
                        input logic wb);
        in_valid = 1'b1;
        in_cmd   = c;
        in_val1  = v1;
        in_val2  = v2;
        in_dest  = d;
        in_wb_en = wb;
    endtask

    function automatic logic [WORD_W-1:0] out_word();
        return {EXE_CMD, valuein1, valuein2, out_dest, out_wb_en};
    endfunction

    function automatic logic [WORD_W-1:0] in_word();
        return {in_cmd, in_val1, in_val2, in_dest, in_wb_en};
    endfunction

    logic [WORD_W-1:0] sb_q[$];
    logic [WORD_W-1:0] cur;
    logic [WORD_W-1:0] stall_word;
    logic              stall_prev;
    int                sent;
    int                rcvd;

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_cmd = '0; in_val1 = '0; in_val2 = '0; in_dest = '0; in_wb_en = 1'b0;

        // ---- reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_exe_cmd",   EXE_CMD, C_NOP);
        chk("rst_val1",      valuein1, 0);
        chk("rst_val2",      valuein2, 0);
        chk("rst_dest",      out_dest, 0);
        chk("rst_wb",        out_wb_en, 0);
        chk("rst_in_ready",  in_ready, 0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // ---- single instruction
        out_ready = 1'b1;
        send(C_ADD, 32'd5, 32'd3, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("one_valid", out_valid, 1);
        chk("one_cmd",   EXE_CMD, C_ADD);
        chk("one_v1",    valuein1, 5);
        chk("one_v2",    valuein2, 3);
        chk("one_dest",  out_dest, 4);
        chk("one_wb",    out_wb_en, 1);
        chk("one_alu",   DATA_W'(valuein1 + valuein2), 8);
        tick();
        chk("one_drain_valid", out_valid, 0);
        chk("one_drain_cmd",   EXE_CMD, C_NOP);
        chk("one_drain_wb",    out_wb_en, 0);
        chk("one_drain_hold",  valuein1, 5);

        // ---- back-pressure into the skid entry
        out_ready = 1'b0;
        send(C_ADD, 32'd10, 32'd1, 5'd1, 1'b1);
        tick();
        chk("bp_a_v1", valuein1, 10);
        chk("bp_busy_ready", in_ready, 1);
        send(C_SUB, 32'd20, 32'd2, 5'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("bp_full_ready", in_ready, 0);
        chk("bp_full_valid", out_valid, 1);
        chk("bp_full_v1",    valuein1, 10);
        tick();
        chk("bp_hold_v1",  valuein1, 10);
        chk("bp_hold_cmd", EXE_CMD, C_ADD);
        out_ready = 1'b1;
        tick();
        chk("bp_b_v1",    valuein1, 20);
        chk("bp_b_cmd",   EXE_CMD, C_SUB);
        chk("bp_b_ready", in_ready, 1);
        tick();
        chk("bp_empty", out_valid, 0);

        // ---- streaming, one per cycle
        for (int i = 0; i < 8; i++) begin
            send(C_ADD, DATA_W'(100 + i), DATA_W'(i), REG_W'(i), 1'b1);
            chk("stream_in_ready", in_ready, 1);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_v1", valuein1, 100 + i);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end", out_valid, 0);

        // ---- undefined command passes through
        send(FUNC_W'(4'hF), 32'd9, 32'd9, 5'd31, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("pass_cmd", EXE_CMD, FUNC_W'(4'hF));
        chk("pass_wb",  out_wb_en, 1);
        tick();

        // ---- flush while FULL with a concurrent input
        out_ready = 1'b0;
        send(C_ADD, 32'd1, 32'd1, 5'd1, 1'b1);
        tick();
        send(C_ADD, 32'd2, 32'd2, 5'd2, 1'b1);
        tick();
        send(C_SUB, 32'd7, 32'd2, 5'd3, 1'b1);
        flush = 1'b1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_cmd",   EXE_CMD, C_NOP);
        chk("flush_wb",    out_wb_en, 0);
        tick();
        chk("flush_no_sub", out_valid, 0);

        // ---- asynchronous reset while BUSY
        send(C_ADD, 32'd33, 32'd44, 5'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("areset_pre", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("areset_valid", out_valid, 0);
        chk("areset_cmd",   EXE_CMD, C_NOP);
        chk("areset_v1",    valuein1, 0);
        chk("areset_v2",    valuein2, 0);
        chk("areset_dest",  out_dest, 0);
        chk("areset_ready", in_ready, 0);
        #1;
        rst = 1'b1;
        tick();
        chk("areset_after", out_valid, 0);

        // ---- random traffic with scoreboard and stall stability
        sent = 0;
        rcvd = 0;
        stall_prev = 1'b0;
        stall_word = '0;
        for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
            if (sent < 1000 && $urandom_range(0, 1) == 1)
                send(FUNC_W'($urandom_range(0, 15)), DATA_W'(sent), DATA_W'($urandom),
                     REG_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            else
                in_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cur = out_word();
            if (stall_prev)
                chk("rand_stall_hold", {out_valid, cur}, {1'b1, stall_word});
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0)
                    chk("rand_underflow", sb_q.size(), 1);
                else
                    chk("rand_data", cur, sb_q.pop_front());
                rcvd++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(in_word());
                sent++;
            end
            stall_prev = out_valid && !out_ready;
            stall_word = cur;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("rand_count", rcvd, 1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
